single_stage_pipeline_register: RTL and testbench

// - One-deep registered stage on a valid/ready stream; breaks the forward data/valid timing path between producer and consumer.
// - Drops into any datapath between two valid/ready interfaces; full throughput (1 word/cycle) when the consumer is always ready.
// - Optional skid mode also registers the ready path back to the producer.

---
 rtl/single_stage_pipeline_register.sv | 115 +++++++++++
 tb/tb_single_stage_pipeline_register.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/single_stage_pipeline_register.sv
// single_stage_pipeline_register
//   One-deep registered stage between two valid/ready interfaces. The forward
//   valid/data path is always registered. Full throughput when the consumer
//   is always ready.
//
//   Build option: define SKID_BUFFER_EN to add a skid register. This also
//   registers in_ready, which removes the combinational path from out_ready
//   back to in_ready.
//
//   Reset is synchronous and active-high. in_ready is held low while rst=1.
module single_stage_pipeline_register #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic accept;
  logic send;

  assign accept = in_valid & in_ready;
  assign send   = out_valid & out_ready;

`ifdef SKID_BUFFER_EN

  // EMPTY: nothing held. FULL: main register valid. SKID: main and skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t                state;
  logic                  in_ready_q;
  logic [DATA_WIDTH-1:0] skid_data;

  // in_ready is a flop (skid empty). Only rst gates it, never out_ready.
  assign in_ready = in_ready_q & ~rst;

  // State machine: the main register feeds out_data, and the skid register
  // catches the word accepted while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared as well, so out_data is never X after reset.
      state      <= ST_EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && send) begin
            out_data <= in_data;
          end else if (accept) begin
            skid_data  <= in_data;
            in_ready_q <= 1'b0;
            state      <= ST_SKID;
          end else if (send) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so no accept can occur in this state.
          if (send) begin
            out_data   <= skid_data;
            in_ready_q <= 1'b1;
            state      <= ST_FULL;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          out_valid  <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

`else

  // Space is available when the stage is empty or when the held word leaves this cycle.
  assign in_ready = ~rst & (~out_valid | out_ready);

  // Single data register: it loads on accept and empties on a send that has no matching accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values.
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else if (send) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_single_stage_pipeline_register.sv
// tb_single_stage_pipeline_register
//   Bench for single_stage_pipeline_register. The reference model is a FIFO
//   queue of words that the consumer has not yet taken.
//   - The head of the queue must appear on out_data.
//   - out_valid is expected when the queue is non-empty.
//   - in_ready depends on occupancy: capacity 1 (base) or 2 (skid).
//   Compile with SKID_BUFFER_EN to match a skid-mode build of the design.
module tb_single_stage_pipeline_register;

  localparam int W = 32;
`ifdef SKID_BUFFER_EN
  localparam int CAPACITY = 2;
`else
  localparam int CAPACITY = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] last_head;
  int           n_sent;

  single_stage_pipeline_register #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle:
  //   1. Drive the inputs at the falling edge.
  //   2. Check the outputs against the model.
  //   3. Advance the model across the rising edge.
  task automatic drive_cycle(input logic r, input logic v, input logic [W-1:0] d,
                             input logic rdy, output logic accepted);
    logic exp_ready;
    logic exp_valid;
    logic snd;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    #1;
    exp_valid = (model_q.size() > 0);
    if (r)
      exp_ready = 1'b0;
    else if (CAPACITY == 1)
      exp_ready = (model_q.size() == 0) || rdy;
    else
      exp_ready = (model_q.size() < CAPACITY);
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    check("out_data", out_data, exp_valid ? model_q[0] : last_head);
    accepted = !r && v && exp_ready;
    snd      = !r && exp_valid && rdy;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      last_head = '0;
    end else begin
      if (snd) begin
        void'(model_q.pop_front());
        n_sent++;
      end
      if (accepted) model_q.push_back(d);
      if (model_q.size() > 0) last_head = model_q[0];
    end
  endtask

  initial begin
    logic         acc;
    logic         pv;
    logic [W-1:0] pd;
    int           n_acc;
    int           cycles;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    last_head = '0;
    n_sent    = 0;

    // Reset: two edges with rst=1. After release with idle inputs, in_ready=1.
    @(posedge clk);
    drive_cycle(1'b1, 1'b0, '0, 1'b0, acc);
    drive_cycle(1'b0, 1'b0, '0, 1'b0, acc);
    check("reset_out_data_zero", out_data, '0);

    // Stall: one word accepted while the consumer is not ready; it is then held.
    drive_cycle(1'b0, 1'b1, 32'hACCEDEDF, 1'b0, acc);
    check("stall_accepted", {31'b0, acc}, 32'd1);
    repeat (3) drive_cycle(1'b0, 1'b0, '0, 1'b0, acc);
    check("stall_hold_data", out_data, 32'hACCEDEDF);

    // Release: the word is sent, and the stage then empties.
    drive_cycle(1'b0, 1'b0, '0, 1'b1, acc);
    drive_cycle(1'b0, 1'b0, '0, 1'b0, acc);
    check("release_sent_count", n_sent, 32'd1);

    // Streaming: back-to-back words through an always-ready consumer.
    for (int i = 1; i <= 4; i++) drive_cycle(1'b0, 1'b1, W'(i), 1'b1, acc);
    repeat (2) drive_cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check("stream_sent_count", n_sent, 32'd5);

    // Mid-operation reset: a stalled word is discarded and never sent.
    drive_cycle(1'b0, 1'b1, 32'h5555_AAAA, 1'b0, acc);
    drive_cycle(1'b0, 1'b0, '0, 1'b0, acc);
    drive_cycle(1'b1, 1'b0, '0, 1'b1, acc);
    drive_cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check("midreset_out_data_zero", out_data, '0);
    drive_cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check("midreset_not_sent", n_sent, 32'd5);

    // Random traffic: the producer holds each word until it is accepted.
    n_sent = 0;
    n_acc  = 0;
    pv     = 1'b0;
    pd     = '0;
    cycles = 0;
    while (n_acc < 1000 && cycles < 20000) begin
      if (!pv && ($urandom_range(3) != 0)) begin
        pv = 1'b1;
        pd = $urandom;
      end
      drive_cycle(1'b0, pv, pv ? pd : W'($urandom), ($urandom_range(2) != 0), acc);
      if (acc) begin
        pv = 1'b0;
        n_acc++;
      end
      cycles++;
    end
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check("random_accept_count", n_acc, 32'd1000);
    check("random_sent_count", n_sent, 32'd1000);
    check("random_drained", model_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
